// File: rtl/csa_tree_pipelined_if.sv
// Handshake and data bundle for the pipelined carry-save reduction tree.
// The slave side is the reduction block; the master side is whoever feeds
// the terms in and drains the redundant/resolved sums out.
interface csa_tree_pipelined_if #(
  parameter int NUM_ELEMENTS = 9,
  parameter int BIT_LEN      = 19,
  parameter int OUT_BIT_LEN  = BIT_LEN + $clog2(NUM_ELEMENTS)
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  terms;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [OUT_BIT_LEN-1:0]                sum_out;
  logic [OUT_BIT_LEN-1:0]                carry_out;
  logic [OUT_BIT_LEN-1:0]                result;

  modport master (
    output in_valid, terms, out_ready,
    input  in_ready, out_valid, sum_out, carry_out, result
  );

  modport slave (
    input  in_valid, terms, out_ready,
    output in_ready, out_valid, sum_out, carry_out, result
  );
endinterface

// File: rtl/csa_tree_pipelined.sv
// Pipelined 3:2 carry-save reduction tree. Each CSA level is one register
// stage; an optional carry-propagate add follows the last level. The whole
// pipeline advances on a single global enable so a downstream stall freezes
// every stage at once.
module csa_tree_pipelined #(
  parameter int NUM_ELEMENTS = 9,
  parameter int BIT_LEN      = 19,
  parameter int FINAL_ADD    = 1,
  parameter int OUT_BIT_LEN  = BIT_LEN + $clog2(NUM_ELEMENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  csa_tree_pipelined_if.slave   bus
);

  // Operand count after one 3:2 level: each triple becomes a pair, leftovers pass.
  function automatic int next_cnt(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Operand count present at tree level k (level 0 = the raw terms).
  function automatic int cnt_at(input int k);
    int n;
    n = NUM_ELEMENTS;
    for (int i = 0; i < k; i++) n = next_cnt(n);
    return n;
  endfunction

  // Number of CSA levels needed to reach two operands.
  function automatic int num_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = next_cnt(n);
        l++;
      end
    end
    return l;
  endfunction

  function automatic logic [OUT_BIT_LEN-1:0] csa_sum(
    input logic [OUT_BIT_LEN-1:0] a, b, c);
    return a ^ b ^ c;
  endfunction

  // Majority shifted left; zero-extended operands leave the MSB free to absorb it.
  function automatic logic [OUT_BIT_LEN-1:0] csa_carry(
    input logic [OUT_BIT_LEN-1:0] a, b, c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  localparam int LEVELS  = num_levels(NUM_ELEMENTS);
  // An explicit output register exists for the final add, or to give the
  // degenerate two-term case a latency of one.
  localparam bit OUT_REG = (FINAL_ADD != 0) || (LEVELS == 0);
  localparam int STAGES  = LEVELS + (OUT_REG ? 1 : 0);

  logic [STAGES-1:0] vld_p;
  logic              advance;

  assign advance       = ~vld_p[STAGES-1] | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p[STAGES-1];

  // Valid bits shift with the data; bubbles enter whenever in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (advance) begin
      vld_p[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  for (genvar g = 0; g <= LEVELS; g++) begin : lvl
    localparam int N = cnt_at(g);
    logic [OUT_BIT_LEN-1:0] d [N];

    if (g == 0) begin : src
      // Zero-extend every term to the output width before any carry shifts.
      always_comb begin
        for (int i = 0; i < N; i++) d[i] = OUT_BIT_LEN'(bus.terms[i]);
      end
    end else begin : csa
      // ---- stage boundary: CSA level g registered ----
      localparam int NP       = cnt_at(g - 1);
      localparam int T        = NP / 3;
      localparam bit LAST_RST = (g == LEVELS) && !OUT_REG;

      // Compress triples in index order; leftovers are appended unchanged.
      always_ff @(posedge clk) begin
        if (LAST_RST && rst) begin
          for (int i = 0; i < N; i++) d[i] <= '0;
        end else if (advance) begin
          for (int t = 0; t < T; t++) begin
            d[2*t]   <= csa_sum(lvl[g-1].d[3*t], lvl[g-1].d[3*t+1], lvl[g-1].d[3*t+2]);
            d[2*t+1] <= csa_carry(lvl[g-1].d[3*t], lvl[g-1].d[3*t+1], lvl[g-1].d[3*t+2]);
          end
          for (int r = 0; r < NP % 3; r++) d[2*T+r] <= lvl[g-1].d[3*T+r];
        end
      end
    end
  end

  logic [OUT_BIT_LEN-1:0] fin_s;
  logic [OUT_BIT_LEN-1:0] fin_c;

  assign fin_s = lvl[LEVELS].d[0];
  assign fin_c = lvl[LEVELS].d[1];

  if (OUT_REG) begin : out_stage
    // ---- stage boundary: final add / output register ----
    logic [OUT_BIT_LEN-1:0] sum_pl;
    logic [OUT_BIT_LEN-1:0] carry_pl;
    logic [OUT_BIT_LEN-1:0] res_pl;

    // Sum and carry are delayed alongside the resolved result.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_pl   <= '0;
        carry_pl <= '0;
        res_pl   <= '0;
      end else if (advance) begin
        sum_pl   <= fin_s;
        carry_pl <= fin_c;
        res_pl   <= (FINAL_ADD != 0) ? fin_s + fin_c : '0;
      end
    end

    assign bus.sum_out   = sum_pl;
    assign bus.carry_out = carry_pl;
    assign bus.result    = res_pl;
  end else begin : redundant_out
    assign bus.sum_out   = fin_s;
    assign bus.carry_out = fin_c;
    assign bus.result    = '0;
  end

endmodule

// File: tb/tb_csa_tree_pipelined.sv
// Bench for the carry-save reduction tree: four configurations, expected
// values queued at issue time and consumed by per-DUT output monitors.
module tb_csa_tree_pipelined;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] s;
    logic [31:0] c;
    bit          chk_sc;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q9[$];
  exp_t q3[$];
  exp_t q4[$];
  exp_t q2[$];

  csa_tree_pipelined_if #(.NUM_ELEMENTS(9), .BIT_LEN(19)) m9();
  csa_tree_pipelined_if #(.NUM_ELEMENTS(3), .BIT_LEN(19)) m3();
  csa_tree_pipelined_if #(.NUM_ELEMENTS(4), .BIT_LEN(19)) m4();
  csa_tree_pipelined_if #(.NUM_ELEMENTS(2), .BIT_LEN(19)) m2();

  csa_tree_pipelined #(.NUM_ELEMENTS(9), .BIT_LEN(19), .FINAL_ADD(1)) u9 (.clk(clk), .rst(rst), .bus(m9));
  csa_tree_pipelined #(.NUM_ELEMENTS(3), .BIT_LEN(19), .FINAL_ADD(1)) u3 (.clk(clk), .rst(rst), .bus(m3));
  csa_tree_pipelined #(.NUM_ELEMENTS(4), .BIT_LEN(19), .FINAL_ADD(0)) u4 (.clk(clk), .rst(rst), .bus(m4));
  csa_tree_pipelined #(.NUM_ELEMENTS(2), .BIT_LEN(19), .FINAL_ADD(0)) u2 (.clk(clk), .rst(rst), .bus(m2));

  assign m3.out_ready = 1'b1;
  assign m4.out_ready = 1'b1;
  assign m2.out_ready = 1'b1;

  // Main DUT downstream: always ready, or a coin flip during the stall phase.
  always @(posedge clk) begin
    #1;
    m9.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic judge(input string nm, input exp_t e, input logic [31:0] s,
                       input logic [31:0] c, input logic [31:0] r,
                       input int d, input int w, input bit fa);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (fa) check({nm, " result"}, r, e.sum);
    else    check({nm, " result0"}, r, 32'd0);
    check({nm, " sum+carry"}, (s + c) & mask, e.sum);
    if (e.chk_sc) begin
      check({nm, " sum_out"}, s, e.s);
      check({nm, " carry_out"}, c, e.c);
    end
    if (e.lat) check({nm, " latency"}, 32'(cyc - e.acc), 32'(d));
  endtask

  // Main monitor: handshake law, stall stability, scoreboard pop.
  bit          held = 1'b0;
  logic [31:0] h_s, h_c, h_r;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      check("n9 in_ready", 32'(m9.in_ready), 32'(!m9.out_valid || m9.out_ready));
      if (held) begin
        check("n9 hold valid", 32'(m9.out_valid), 32'd1);
        check("n9 hold sum", 32'(m9.sum_out), h_s);
        check("n9 hold carry", 32'(m9.carry_out), h_c);
        check("n9 hold result", 32'(m9.result), h_r);
      end
      held = m9.out_valid && !m9.out_ready;
      h_s = 32'(m9.sum_out);
      h_c = 32'(m9.carry_out);
      h_r = 32'(m9.result);
      if (m9.out_valid && m9.out_ready) begin
        if (q9.size() == 0) check("n9 spurious output", 32'd1, 32'd0);
        else judge("n9", q9.pop_front(), 32'(m9.sum_out), 32'(m9.carry_out), 32'(m9.result), 5, 23, 1'b1);
      end
    end
  end

  // Monitors for the small configurations (always ready downstream).
  always @(negedge clk) begin
    if (!rst && m3.out_valid) begin
      if (q3.size() == 0) check("n3 spurious output", 32'd1, 32'd0);
      else judge("n3", q3.pop_front(), 32'(m3.sum_out), 32'(m3.carry_out), 32'(m3.result), 2, 21, 1'b1);
    end
    if (!rst && m4.out_valid) begin
      if (q4.size() == 0) check("n4 spurious output", 32'd1, 32'd0);
      else judge("n4", q4.pop_front(), 32'(m4.sum_out), 32'(m4.carry_out), 32'(m4.result), 2, 21, 1'b0);
    end
    if (!rst && m2.out_valid) begin
      if (q2.size() == 0) check("n2 spurious output", 32'd1, 32'd0);
      else judge("n2", q2.pop_front(), 32'(m2.sum_out), 32'(m2.carry_out), 32'(m2.result), 1, 20, 1'b0);
    end
  end

  function automatic exp_t mk(input logic [31:0] sum, input logic [31:0] s,
                              input logic [31:0] c, input bit sc, input bit lat);
    exp_t e;
    e.sum = sum; e.s = s; e.c = c; e.chk_sc = sc; e.acc = cyc; e.lat = lat;
    return e;
  endfunction

  // Offer one N=9 vector, waiting (bounded) for in_ready; called at posedge+1.
  task automatic send9(input logic [8:0][18:0] t, input bit lat);
    logic [31:0] s;
    int          n;
    s = 0;
    for (int i = 0; i < 9; i++) s += 32'(t[i]);
    m9.in_valid = 1'b1;
    m9.terms    = t;
    n = 0;
    forever begin
      @(negedge clk);
      if (m9.in_ready) break;
      @(posedge clk); #1;
      n++;
      if (n > 200) break;
    end
    if (n > 200) check("n9 accept timeout", 32'd1, 32'd0);
    else q9.push_back(mk(s, 0, 0, 1'b0, lat));
    @(posedge clk); #1;
    m9.in_valid = 1'b0;
  endtask

  task automatic rand9(output logic [8:0][18:0] t);
    for (int i = 0; i < 9; i++) t[i] = 19'($urandom);
  endtask

  task automatic send3(input logic [2:0][18:0] t, input logic [31:0] se, input logic [31:0] ce, input bit sc);
    logic [31:0] s;
    s = 32'(t[0]) + 32'(t[1]) + 32'(t[2]);
    m3.in_valid = 1'b1; m3.terms = t;
    @(negedge clk);
    q3.push_back(mk(s, se, ce, sc, 1'b1));
    @(posedge clk); #1;
    m3.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0][18:0] t);
    logic [31:0] s;
    s = 32'(t[0]) + 32'(t[1]) + 32'(t[2]) + 32'(t[3]);
    m4.in_valid = 1'b1; m4.terms = t;
    @(negedge clk);
    q4.push_back(mk(s, 0, 0, 1'b0, 1'b1));
    @(posedge clk); #1;
    m4.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0][18:0] t);
    m2.in_valid = 1'b1; m2.terms = t;
    @(negedge clk);
    q2.push_back(mk(32'(t[0]) + 32'(t[1]), 32'(t[0]), 32'(t[1]), 1'b1, 1'b1));
    @(posedge clk); #1;
    m2.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((q9.size() + q3.size() + q4.size() + q2.size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("drain timeout", 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [8:0][18:0] t9;
    logic [2:0][18:0] t3;
    logic [3:0][18:0] t4;
    logic [1:0][18:0] t2;

    m9.in_valid = 1'b0; m9.terms = '0;
    m3.in_valid = 1'b0; m3.terms = '0;
    m4.in_valid = 1'b0; m4.terms = '0;
    m2.in_valid = 1'b0; m2.terms = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst out_valid", 32'(m9.out_valid), 32'd0);
    check("rst in_ready", 32'(m9.in_ready), 32'd1);
    check("rst sum_out", 32'(m9.sum_out), 32'd0);
    check("rst carry_out", 32'(m9.carry_out), 32'd0);
    check("rst result", 32'(m9.result), 32'd0);
    check("rst n3 out_valid", 32'(m3.out_valid), 32'd0);
    check("rst n4 out_valid", 32'(m4.out_valid), 32'd0);
    check("rst n2 out_valid", 32'(m2.out_valid), 32'd0);
    @(posedge clk); #1;

    // Directed N=3 example, then random vectors on the small configurations.
    t3[0] = 19'h457ED; t3[1] = 19'h5F78C; t3[2] = 19'h5E9F9;
    send3(t3, 32'h44998, 32'hBEFDA, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) t3[i] = 19'($urandom);
      send3(t3, 0, 0, 1'b0);
    end
    t4 = '1;
    send4(t4);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) t4[i] = 19'($urandom);
      send4(t4);
    end
    t2[0] = 19'h7FFFF; t2[1] = 19'h7FFFF;
    send2(t2);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 2; i++) t2[i] = 19'($urandom);
      send2(t2);
    end

    // N=9 all-ones boundary, isolated to check latency.
    t9 = '1;
    send9(t9, 1'b1);
    wait_empty();

    // Back-to-back random stream with free-flowing output.
    for (int k = 0; k < 20; k++) begin
      rand9(t9);
      send9(t9, 1'b1);
    end
    wait_empty();

    // Random downstream stalls and random input gaps.
    rand_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      rand9(t9);
      send9(t9, 1'b0);
    end
    rand_rdy = 1'b0;
    wait_empty();

    // Reset with three reductions in flight, then a fresh reduction.
    for (int k = 0; k < 3; k++) begin
      rand9(t9);
      send9(t9, 1'b0);
    end
    rst = 1'b1;
    q9.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid-rst out_valid", 32'(m9.out_valid), 32'd0);
    check("mid-rst sum_out", 32'(m9.sum_out), 32'd0);
    check("mid-rst carry_out", 32'(m9.carry_out), 32'd0);
    check("mid-rst result", 32'(m9.result), 32'd0);
    check("mid-rst in_ready", 32'(m9.in_ready), 32'd1);
    @(posedge clk); #1;
    repeat (8) @(posedge clk);
    #1;
    rand9(t9);
    send9(t9, 1'b1);
    wait_empty();

    check("n9 queue empty", 32'(q9.size()), 32'd0);
    check("n3 queue empty", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
